// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: default widths, command and
// latency constants, sequencer state encoding and the request record.
package alu_pkg;

  localparam int N1_DEF    = 8;
  localparam int N2_DEF    = 4;
  localparam int TAG_W_DEF = 8;

  localparam logic [3:0] CMD_MUL_I = 4'd9;
  localparam logic [3:0] CMD_MUL_S = 4'd10;

  localparam int LAT_STD = 1;
  localparam int LAT_MUL = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    MUL_WAIT = 2'd2
  } seq_state_t;

  // Default-width request record; the sequencer builds its own from its parameters.
  typedef struct packed {
    logic [TAG_W_DEF-1:0] tag;
    logic [N1_DEF-1:0]    opa;
    logic [N1_DEF-1:0]    opb;
    logic [N2_DEF-1:0]    cmd;
    logic                 mode;
    logic                 cin;
    logic [1:0]           in_valid;
  } alu_req_t;

endpackage

// File: rtl/alu_req_fifo.sv
// In-order request buffer: DEPTH entries, pointers wrap modulo DEPTH and the
// registered count tells full from empty. Callers never push when full or pop when empty.
module alu_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage in front of the ALU: buffers tagged requests, presents one op at a
// time (holding multiplies for their extra cycle) and emits a tag aligned with RES.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int N1    = N1_DEF,
  parameter int N2    = N2_DEF,
  parameter int DEPTH = 4,
  parameter int TAG_W = TAG_W_DEF,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [TAG_W-1:0] REQ_TAG,
  input  logic [N1-1:0]    REQ_OPA,
  input  logic [N1-1:0]    REQ_OPB,
  input  logic [N2-1:0]    REQ_CMD,
  input  logic             REQ_MODE,
  input  logic             REQ_CIN,
  input  logic [1:0]       REQ_IN_VALID,
  output logic [N1-1:0]    OPA,
  output logic [N1-1:0]    OPB,
  output logic [N2-1:0]    CMD,
  output logic             MODE,
  output logic             CIN,
  output logic [1:0]       IN_VALID,
  output logic             CE,
  output logic             RSP_VALID,
  output logic [TAG_W-1:0] RSP_TAG,
  output logic [LW-1:0]    LEVEL,
  output logic             BUSY,
  output seq_state_t       DBG_STATE
);

  // Handshake: a request transfers on any edge where REQ_VALID && REQ_READY.
  // REQ_READY depends only on registered state, never on REQ_VALID or a same-cycle pop.

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [N1-1:0]    opa;
    logic [N1-1:0]    opb;
    logic [N2-1:0]    cmd;
    logic             mode;
    logic             cin;
    logic [1:0]       in_valid;
  } req_t;

  seq_state_t       state_q, state_d;
  req_t             fifo_wdata, fifo_head, op_q;
  logic             push, pop, fifo_empty, op_is_mul, issuing;
  logic             run_q;
  logic             s0_v, s1_v;
  logic [TAG_W-1:0] s0_tag, s1_tag;

  assign fifo_wdata = '{tag: REQ_TAG, opa: REQ_OPA, opb: REQ_OPB, cmd: REQ_CMD,
                        mode: REQ_MODE, cin: REQ_CIN, in_valid: REQ_IN_VALID};

  assign REQ_READY = run_q && (LEVEL < LW'(DEPTH));
  assign push      = REQ_VALID && REQ_READY;

  alu_req_fifo #(.W($bits(req_t)), .DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .count (LEVEL)
  );

  assign fifo_empty = (LEVEL == '0);
  assign op_is_mul  = op_q.mode && (op_q.cmd == N2'(CMD_MUL_I) || op_q.cmd == N2'(CMD_MUL_S));
  assign issuing    = (state_q == ISSUE);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The pop is decided here because popping is exactly "entering ISSUE".
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = ISSUE;
          pop     = 1'b1;
        end
      end
      ISSUE: begin
        if (op_is_mul) begin
          state_d = MUL_WAIT;
        end else if (!fifo_empty) begin
          state_d = ISSUE;
          pop     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      MUL_WAIT: begin
        if (!fifo_empty) begin
          state_d = ISSUE;
          pop     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    OPA      = '0;
    OPB      = '0;
    CMD      = '0;
    MODE     = 1'b0;
    CIN      = 1'b0;
    IN_VALID = 2'b00;
    if (state_q != IDLE) begin
      OPA  = op_q.opa;
      OPB  = op_q.opb;
      CMD  = op_q.cmd;
      MODE = op_q.mode;
      CIN  = op_q.cin;
    end
    if (issuing) IN_VALID = op_q.in_valid;
  end

  always_ff @(posedge CLK) begin
    if (RST)      op_q <= '0;
    else if (pop) op_q <= fifo_head;
  end

  // Tag pipe: the edge that ends an ISSUE cycle is when the ALU samples the op.
  // Single-cycle ops go straight to the response stage, multiplies take one extra stage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s0_v   <= 1'b0;
      s0_tag <= '0;
      s1_v   <= 1'b0;
      s1_tag <= '0;
    end else begin
      s0_v   <= issuing && op_is_mul;
      s0_tag <= (issuing && op_is_mul) ? op_q.tag : '0;
      if (issuing && !op_is_mul) begin
        s1_v   <= 1'b1;
        s1_tag <= op_q.tag;
      end else begin
        s1_v   <= s0_v;
        s1_tag <= s0_tag;
      end
    end
  end

  always_ff @(posedge CLK) begin
    run_q <= !RST;
  end

  assign CE        = run_q;
  assign RSP_VALID = s1_v;
  assign RSP_TAG   = s1_tag;
  assign BUSY      = (state_q != IDLE) || !fifo_empty || s0_v || s1_v;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: per-scenario tasks with hand-computed
// expectations and a tag queue for the long multiply stream.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [7:0] REQ_TAG;
  logic [7:0] REQ_OPA, REQ_OPB;
  logic [3:0] REQ_CMD;
  logic       REQ_MODE, REQ_CIN;
  logic [1:0] REQ_IN_VALID;
  logic [7:0] OPA, OPB;
  logic [3:0] CMD;
  logic       MODE, CIN;
  logic [1:0] IN_VALID;
  logic       CE, RSP_VALID;
  logic [7:0] RSP_TAG;
  logic [2:0] LEVEL;
  logic       BUSY;
  seq_state_t DBG_STATE;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  alu_op_sequencer #(.N1(8), .N2(4), .DEPTH(4), .TAG_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_TAG(REQ_TAG),
    .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB), .REQ_CMD(REQ_CMD),
    .REQ_MODE(REQ_MODE), .REQ_CIN(REQ_CIN), .REQ_IN_VALID(REQ_IN_VALID),
    .OPA(OPA), .OPB(OPB), .CMD(CMD), .MODE(MODE), .CIN(CIN),
    .IN_VALID(IN_VALID), .CE(CE), .RSP_VALID(RSP_VALID), .RSP_TAG(RSP_TAG),
    .LEVEL(LEVEL), .BUSY(BUSY), .DBG_STATE(DBG_STATE)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  // Driver tasks
  task automatic drive_req(input logic [7:0] tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] cmd, input logic mode, input logic [1:0] iv);
    REQ_VALID    = 1'b1;
    REQ_TAG      = tag;
    REQ_OPA      = a;
    REQ_OPB      = b;
    REQ_CMD      = cmd;
    REQ_MODE     = mode;
    REQ_CIN      = 1'b0;
    REQ_IN_VALID = iv;
  endtask

  task automatic idle_req();
    REQ_VALID    = 1'b0;
    REQ_TAG      = '0;
    REQ_OPA      = '0;
    REQ_OPB      = '0;
    REQ_CMD      = '0;
    REQ_MODE     = 1'b0;
    REQ_CIN      = 1'b0;
    REQ_IN_VALID = 2'b00;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle_req();
    repeat (2) @(negedge CLK);
    checks++; if (LEVEL !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", LEVEL); end
    checks++; if (CE !== 1'b0) begin failures++; $display("FAIL reset_ce got=%b exp=0", CE); end
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL reset_ready_first got=%b exp=1", REQ_READY); end
    drive_req(8'h70, 8'h01, 8'h02, 4'd0, 1'b1, 2'b11);
    @(negedge CLK);
    drive_req(8'h71, 8'h03, 8'h04, 4'd0, 1'b1, 2'b11);
    @(negedge CLK);
    idle_req();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if ({OPA, OPB, CMD, MODE, CIN} !== 22'd0) begin failures++; $display("FAIL reset_alu_ops got=%h exp=0", {OPA, OPB, CMD, MODE, CIN}); end
    checks++; if (IN_VALID !== 2'b00) begin failures++; $display("FAIL reset_in_valid got=%b exp=00", IN_VALID); end
    checks++; if (RSP_VALID !== 1'b0 || RSP_TAG !== 8'h00) begin failures++; $display("FAIL reset_rsp got=%b/%h exp=0/00", RSP_VALID, RSP_TAG); end
    checks++; if (LEVEL !== 3'd0 || BUSY !== 1'b0) begin failures++; $display("FAIL reset_level_busy got=%0d/%b exp=0/0", LEVEL, BUSY); end
    checks++; if (REQ_READY !== 1'b0 || CE !== 1'b0) begin failures++; $display("FAIL reset_ready_ce got=%b/%b exp=0/0", REQ_READY, CE); end
    checks++; if (DBG_STATE !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", DBG_STATE, IDLE); end
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (REQ_READY !== 1'b1 || CE !== 1'b1) begin failures++; $display("FAIL reset_release got=%b/%b exp=1/1", REQ_READY, CE); end
  endtask

  task automatic test_single_op();
    drive_req(8'h11, 8'h05, 8'h03, 4'd0, 1'b1, 2'b11);
    @(negedge CLK);
    idle_req();
    checks++; if (IN_VALID !== 2'b00 || LEVEL !== 3'd1) begin failures++; $display("FAIL single_e0 got=%b/%0d exp=00/1", IN_VALID, LEVEL); end
    @(negedge CLK);
    checks++; if (OPA !== 8'h05 || OPB !== 8'h03 || CMD !== 4'd0 || MODE !== 1'b1) begin
      failures++; $display("FAIL single_operands got=%h/%h/%h/%b exp=05/03/0/1", OPA, OPB, CMD, MODE); end
    checks++; if (IN_VALID !== 2'b11) begin failures++; $display("FAIL single_in_valid got=%b exp=11", IN_VALID); end
    checks++; if (RSP_VALID !== 1'b0) begin failures++; $display("FAIL single_rsp_early got=%b exp=0", RSP_VALID); end
    @(negedge CLK);
    checks++; if (RSP_VALID !== 1'b1 || RSP_TAG !== 8'h11) begin failures++; $display("FAIL single_rsp got=%b/%h exp=1/11", RSP_VALID, RSP_TAG); end
    checks++; if (IN_VALID !== 2'b00) begin failures++; $display("FAIL single_in_valid_after got=%b exp=00", IN_VALID); end
    @(negedge CLK);
    checks++; if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL single_done got=%b/%b exp=0/0", RSP_VALID, BUSY); end
  endtask

  task automatic test_mul_then_add();
    drive_req(8'h22, 8'h04, 8'h06, CMD_MUL_I, 1'b1, 2'b11);
    @(negedge CLK);
    drive_req(8'h33, 8'h07, 8'h01, 4'd0, 1'b1, 2'b11);
    @(negedge CLK);
    idle_req();
    checks++; if (IN_VALID !== 2'b11 || CMD !== 4'd9 || OPA !== 8'h04) begin
      failures++; $display("FAIL mul_issue got=%b/%h/%h exp=11/9/04", IN_VALID, CMD, OPA); end
    @(negedge CLK);
    checks++; if (IN_VALID !== 2'b00 || OPA !== 8'h04 || CMD !== 4'd9) begin
      failures++; $display("FAIL mul_wait_hold got=%b/%h/%h exp=00/04/9", IN_VALID, OPA, CMD); end
    checks++; if (DBG_STATE !== MUL_WAIT || RSP_VALID !== 1'b0) begin
      failures++; $display("FAIL mul_wait_state got=%0d/%b exp=%0d/0", DBG_STATE, RSP_VALID, MUL_WAIT); end
    @(negedge CLK);
    checks++; if (IN_VALID !== 2'b11 || CMD !== 4'd0 || OPA !== 8'h07) begin
      failures++; $display("FAIL add_after_mul got=%b/%h/%h exp=11/0/07", IN_VALID, CMD, OPA); end
    checks++; if (RSP_VALID !== 1'b1 || RSP_TAG !== 8'h22) begin failures++; $display("FAIL mul_rsp got=%b/%h exp=1/22", RSP_VALID, RSP_TAG); end
    @(negedge CLK);
    checks++; if (RSP_VALID !== 1'b1 || RSP_TAG !== 8'h33) begin failures++; $display("FAIL add_rsp got=%b/%h exp=1/33", RSP_VALID, RSP_TAG); end
    @(negedge CLK);
    checks++; if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL mul_add_done got=%b/%b exp=0/0", RSP_VALID, BUSY); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_iv;
    logic       exp_rv;
    for (int n = 0; n < 8; n++) begin
      if (n < 4) drive_req(8'(n + 1), 8'(n + 1), 8'h10, 4'd0, 1'b1, 2'b11);
      else idle_req();
      @(negedge CLK);
      exp_iv = (n >= 1 && n <= 4) ? 2'b11 : 2'b00;
      exp_rv = (n >= 2 && n <= 5);
      checks++; if (IN_VALID !== exp_iv) begin failures++; $display("FAIL b2b_in_valid[%0d] got=%b exp=%b", n, IN_VALID, exp_iv); end
      if (n >= 1 && n <= 4) begin
        checks++; if (OPA !== 8'(n)) begin failures++; $display("FAIL b2b_opa[%0d] got=%h exp=%h", n, OPA, 8'(n)); end
      end
      checks++; if (RSP_VALID !== exp_rv) begin failures++; $display("FAIL b2b_rsp_valid[%0d] got=%b exp=%b", n, RSP_VALID, exp_rv); end
      if (n >= 2 && n <= 5) begin
        checks++; if (RSP_TAG !== 8'(n - 1)) begin failures++; $display("FAIL b2b_rsp_tag[%0d] got=%h exp=%h", n, RSP_TAG, 8'(n - 1)); end
      end
    end
  endtask

  task automatic test_pass_through();
    drive_req(8'h55, 8'h5A, 8'hA5, 4'd0, 1'b1, 2'b00);
    @(negedge CLK);
    idle_req();
    @(negedge CLK);
    checks++; if (IN_VALID !== 2'b00 || OPA !== 8'h5A || DBG_STATE !== ISSUE) begin
      failures++; $display("FAIL pass_issue got=%b/%h/%0d exp=00/5a/%0d", IN_VALID, OPA, DBG_STATE, ISSUE); end
    @(negedge CLK);
    checks++; if (RSP_VALID !== 1'b1 || RSP_TAG !== 8'h55) begin failures++; $display("FAIL pass_rsp got=%b/%h exp=1/55", RSP_VALID, RSP_TAG); end
    @(negedge CLK);
  endtask

  task automatic test_full_fifo();
    int sent, rcvd, last_rsp, saw_full;
    logic [7:0] exp_tag;
    sent = 0; rcvd = 0; last_rsp = -1; saw_full = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 100 && rcvd < 10; cyc++) begin
      if (sent < 10) drive_req(8'(8'hA0 + sent), 8'(sent + 2), 8'h03, CMD_MUL_I, 1'b1, 2'b11);
      else idle_req();
      if (REQ_VALID && REQ_READY) begin
        exp_q.push_back(8'(8'hA0 + sent));
        sent++;
      end
      @(negedge CLK);
      if (LEVEL == 3'd4) begin
        saw_full = 1;
        checks++; if (REQ_READY !== 1'b0) begin failures++; $display("FAIL full_ready[%0d] got=%b exp=0", cyc, REQ_READY); end
      end
      if (RSP_VALID === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL full_extra_rsp got=%h exp=none", RSP_TAG);
        end else begin
          exp_tag = exp_q.pop_front();
          if (RSP_TAG !== exp_tag) begin failures++; $display("FAIL full_rsp_tag got=%h exp=%h", RSP_TAG, exp_tag); end
        end
        if (last_rsp >= 0) begin
          checks++; if (cyc - last_rsp != 2) begin failures++; $display("FAIL full_rsp_spacing got=%0d exp=2", cyc - last_rsp); end
        end
        last_rsp = cyc;
        rcvd++;
      end
    end
    idle_req();
    checks++; if (rcvd != 10) begin failures++; $display("FAIL full_rsp_count got=%0d exp=10", rcvd); end
    checks++; if (saw_full != 1) begin failures++; $display("FAIL full_reached got=%0d exp=1", saw_full); end
    repeat (2) @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL full_drained got=%b exp=0", BUSY); end
  endtask

  task automatic test_reset_mid_op();
    for (int n = 0; n < 5; n++) begin
      drive_req(8'(8'hB1 + n), 8'h02, 8'h02, CMD_MUL_S, 1'b1, 2'b11);
      @(negedge CLK);
    end
    idle_req();
    checks++; if (DBG_STATE !== MUL_WAIT || LEVEL !== 3'd3) begin
      failures++; $display("FAIL rmid_setup got=%0d/%0d exp=%0d/3", DBG_STATE, LEVEL, MUL_WAIT); end
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (LEVEL !== 3'd0 || IN_VALID !== 2'b00 || BUSY !== 1'b0) begin
      failures++; $display("FAIL rmid_flush got=%0d/%b/%b exp=0/00/0", LEVEL, IN_VALID, BUSY); end
    checks++; if (RSP_VALID !== 1'b0) begin failures++; $display("FAIL rmid_rsp got=%b exp=0", RSP_VALID); end
    RST = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge CLK);
      checks++; if (RSP_VALID !== 1'b0) begin failures++; $display("FAIL rmid_quiet[%0d] got=%b/%h exp=0", n, RSP_VALID, RSP_TAG); end
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_mul_then_add();
    test_back_to_back();
    test_pass_through();
    test_full_fifo();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Issue stage directly upstream of `alu_rtl_design`. It accepts tagged operation requests on a valid/ready interface and buffers them in a small in-order FIFO. It drives the ALU operand, command and control inputs one operation at a time, respecting the longer multiply latency. It emits a response strobe plus tag, cycle-aligned with the ALU result, so a downstream checker or collector can pair `RES` and flags with the originating request.

## Interface
- `N1`, 8, operand width (matches ALU `OPA`/`OPB`)
- `N2`, 4, command width (matches ALU `CMD`)
- `DEPTH`, 4, request FIFO entries (power of two, ≥2)
- `TAG_W`, 8, request tag width (feature-ID width)

Clocking and reset: one clock, `CLK`; reset `RST` is synchronous and active-high.

- `CLK`  in  1  clock
- `RST`  in  1  synchronous active-high reset
- `REQ_VALID`  in  1  request present
- `REQ_READY`  out  1  FIFO can accept
- `REQ_TAG`  in  TAG_W  request tag
- `REQ_OPA`, `REQ_OPB`  in  N1  operands
- `REQ_CMD`  in  N2  command
- `REQ_MODE`, `REQ_CIN`  in  1  mode (1 = arithmetic), carry-in
- `REQ_IN_VALID`  in  2  operand-valid bits, passed through
- `OPA`, `OPB`  out  N1  to ALU
- `CMD`  out  N2  to ALU
- `MODE`, `CIN`  out  1  to ALU
- `IN_VALID`  out  2  to ALU; 00 when no op is issued
- `CE`  out  1  ALU clock enable
- `RSP_VALID`  out  1  ALU result valid this cycle
- `RSP_TAG`  out  TAG_W  tag of that result
- `LEVEL`  out  $clog2(DEPTH+1)  FIFO occupancy
- `BUSY`  out  1  FIFO non-empty or op in flight

## Operation
- **Push rule:** a request is pushed on `REQ_VALID && REQ_READY`.
- **`REQ_READY`** = `LEVEL < DEPTH`, from registered count. There is no full-bypass: `REQ_READY` stays low when full, even if a pop occurs that cycle.
- **Multiply class:** `MODE==1 && (CMD==9 || CMD==10)`. Latency is 2 ALU cycles. All other ops have latency 1.
- **FSM states:**
  - IDLE: nothing on ALU inputs.
  - ISSUE: op on ALU inputs, `IN_VALID` = request value.
  - MUL_WAIT: `IN_VALID`=00, operands held.
- **Transitions:**
  - IDLE/ISSUE → ISSUE when FIFO non-empty and (state is IDLE, or the current ISSUE op is non-multiply).
  - ISSUE(multiply) → MUL_WAIT.
  - MUL_WAIT → ISSUE if FIFO non-empty, else IDLE.
  - ISSUE(non-mul) → IDLE if FIFO empty.
- **Throughput:** back-to-back non-multiply ops issue every cycle; multiplies issue every 2 cycles.
- **No fall-through:** a pushed entry is never issued in its push cycle.
- **Pass-through:** `REQ_IN_VALID`=00 requests are accepted and issued unchanged. They produce an RSP; the ALU reports `ERR`.
- **Response tracking:** a 2-entry tag/latency shift register tracks in-flight tags. `RSP_VALID` is a one-cycle pulse per issued op, strictly in issue order.
- **`CE`:** 0 in reset, 1 otherwise.
- **`BUSY`:** `state!=IDLE || LEVEL!=0 || tag pipe non-empty`.

## Timing
- **Reset values:** all outputs 0, except `REQ_READY`, which is 1 in the cycle after reset deasserts. `LEVEL`=0, state IDLE.
- **Handshake to ALU inputs:** request accepted at edge e0 → ALU inputs driven after e1 for exactly one cycle (ALU samples at e2).
- **Response alignment:**
  - Non-multiply: `RSP_VALID`/`RSP_TAG` high after e2, for one cycle.
  - Multiply: high after e3, for one cycle.
- **Simultaneous push and pop:** `LEVEL` unchanged; FIFO order is preserved.
- **Pointer wrap:** FIFO pointers wrap modulo `DEPTH`; full and empty are distinguished via count.
- **Reset mid-operation:** FIFO flushed, in-flight tags dropped, no `RSP_VALID` for any flushed or in-flight op, `IN_VALID`=00 next cycle.

## Structure
- **`alu_pkg`:**
  - defaults for `N1`/`N2`/`TAG_W`
  - command constants `CMD_MUL_I`=4'd9, `CMD_MUL_S`=4'd10
  - latency constants `LAT_STD`=1, `LAT_MUL`=2
  - FSM state enum {IDLE, ISSUE, MUL_WAIT}
  - request struct {tag, opa, opb, cmd, mode, cin, in_valid}
- **Sub-module `alu_req_fifo`:** synchronous `DEPTH`-entry FIFO with push/pop/count. The sequencer top holds the FSM and tag pipe.

## Test plan
- **Reset:** `RST` high 2 cycles mid-traffic → all outputs 0, `LEVEL`=0; `REQ_READY`=1 the next cycle.
- **Single op:** ADD (`MODE`=1, `CMD`=0, `OPA`=8'h05, `OPB`=8'h03, `IN_VALID`=11, tag 8'h11) accepted at e0 → `OPA`/`OPB`/`CMD`/`IN_VALID`=11 after e1 for one cycle; `RSP_VALID`, `RSP_TAG`=8'h11 after e2 only.
- **Multiply then ADD:** MUL `CMD`=9 tag 8'h22, then ADD tag 8'h33, pushed in consecutive cycles → MUL issued after e1; `IN_VALID`=00 after e2; ADD issued after e3; RSP 8'h22 after e3, RSP 8'h33 after e4.
- **Back-to-back ADDs:** 4 ADDs tags 1–4 pushed in consecutive cycles → issued in 4 consecutive cycles; `RSP_VALID` high 4 consecutive cycles with tags 1,2,3,4.
- **Full FIFO:** 10 multiplies pushed with `REQ_VALID` held high → `REQ_READY` low whenever `LEVEL`=4; all 10 tags appear on `RSP_TAG` in order at 2-cycle spacing, none dropped or duplicated.
- **Reset mid-operation:** `RST` asserted during MUL_WAIT with 3 entries queued → next cycle `LEVEL`=0, `IN_VALID`=00, `BUSY`=0; no `RSP_VALID` thereafter until new traffic.
